// File: rtl/sorter_sensor_classifier_if.sv
// Classification handoff from the sensing station to the barrier stepper.
// Handshake: class_code is meaningful and held while class_valid = 1; a
// transfer completes on any rising edge where class_valid & class_ready.
interface sorter_sensor_classifier_if;
  logic       class_valid;
  logic       class_ready;
  logic [1:0] class_code;

  modport master (output class_valid, output class_code, input class_ready);
  modport slave  (input class_valid, input class_code, output class_ready);
endinterface

// File: rtl/sorter_sensor_classifier.sv
// Sensor conditioning, object detection and windowed material classification
// feeding one 2-bit class code per object to the barrier stepper.
module sorter_sensor_classifier #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WINDOW_CYCLES   = 5000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capacitive,
  input  logic                         inductive,
  input  logic                         photo,
  sorter_sensor_classifier_if.master   cls,
  output logic                         busy,
  output logic [7:0]                   obj_count,
  output logic [1:0]                   dbg_state_o
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SAMPLE     = 2'd1,
    S_PRESENT    = 2'd2,
    S_WAIT_CLEAR = 2'd3
  } state_e;

  // Bit order for the conditioning arrays: [0]=capacitive [1]=inductive [2]=photo
  logic [2:0]      raw;
  logic [2:0]      sync1_q, sync2_q, db_q;
  logic [DB_W-1:0] db_cnt_q [3];

  assign raw = {photo, inductive, capacitive};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_MAX) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic cap_db, ind_db, photo_db;
  assign cap_db   = db_q[0];
  assign ind_db   = db_q[1];
  assign photo_db = db_q[2];

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             ind_seen_q, ind_seen_d;
  logic             cap_seen_q, cap_seen_d;
  logic [1:0]       code_q, code_d;
  logic [7:0]       count_q, count_d;
  logic             photo_prev_q;
  logic             photo_rise;

  assign photo_rise = photo_db & ~photo_prev_q;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    ind_seen_d = ind_seen_q;
    cap_seen_d = cap_seen_q;
    code_d     = code_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (photo_rise) begin
          ind_seen_d = 1'b0;
          cap_seen_d = 1'b0;
          win_d      = WIN_MAX;
          state_d    = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        ind_seen_d = ind_seen_q | ind_db;
        cap_seen_d = cap_seen_q | cap_db;
        if (win_q == '0) begin
          // The final sampled cycle still contributes to the class decision.
          state_d = S_PRESENT;
          if (ind_seen_d)      code_d = 2'b01;
          else if (cap_seen_d) code_d = 2'b10;
          else                 code_d = 2'b11;
        end else begin
          win_d = win_q - 1'b1;
        end
      end
      S_PRESENT: begin
        if (cls.class_ready) begin
          count_d = count_q + 8'd1;
          code_d  = 2'b00;
          state_d = S_WAIT_CLEAR;
        end
      end
      S_WAIT_CLEAR: begin
        if (!photo_db) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      win_q        <= '0;
      ind_seen_q   <= 1'b0;
      cap_seen_q   <= 1'b0;
      code_q       <= 2'b00;
      count_q      <= 8'd0;
      photo_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      ind_seen_q   <= ind_seen_d;
      cap_seen_q   <= cap_seen_d;
      code_q       <= code_d;
      count_q      <= count_d;
      photo_prev_q <= photo_db;
    end
  end

  assign cls.class_valid = (state_q == S_PRESENT);
  assign cls.class_code  = code_q;
  assign busy            = (state_q != S_IDLE);
  assign obj_count       = count_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_sorter_sensor_classifier.sv
// Bench for sorter_sensor_classifier: directed scenarios plus randomized
// objects checked against a timing/classification model of the sensing station.
module tb_sorter_sensor_classifier;

  localparam int DEB = 4;
  localparam int WIN = 8;
  // Raw photo rise -> 2 sync + DEB debounce -> busy one edge later.
  localparam int EXP_BUSY  = 2 + DEB + 1;
  localparam int EXP_VALID = EXP_BUSY + WIN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       capacitive, inductive, photo;
  logic       busy;
  logic [7:0] obj_count;
  logic [1:0] dbg_state;

  sorter_sensor_classifier_if cls_if ();

  sorter_sensor_classifier #(
    .DEBOUNCE_CYCLES (DEB),
    .WINDOW_CYCLES   (WIN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .capacitive  (capacitive),
    .inductive   (inductive),
    .photo       (photo),
    .cls         (cls_if.master),
    .busy        (busy),
    .obj_count   (obj_count),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  logic [1:0] exp_q[$];

  // ---------------- reference model ----------------
  // A sensor raised d edges after photo is debounced at d+2+DEB; the last
  // sampled cycle starts at photo debounce + WIN, so it counts when d <= WIN.
  function automatic logic [1:0] model_class(bit use_ind, int ind_delay, bit cap);
    bit ind_seen;
    ind_seen = use_ind && (ind_delay <= WIN);
    if (ind_seen) return 2'b01;
    if (cap)      return 2'b10;
    return 2'b11;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_obj(input bit use_ind, input int ind_delay, input bit cap,
                         output logic [1:0] code, output int busy_lat,
                         output int valid_lat, output bit to);
    int t;
    t = 0; busy_lat = -1; valid_lat = -1; to = 1'b1; code = 2'bxx;
    photo = 1'b1;
    capacitive = cap;
    for (int i = 0; i < 60; i++) begin
      if (use_ind && t == ind_delay) inductive = 1'b1;
      tick();
      t++;
      if (busy === 1'b1 && busy_lat < 0) busy_lat = t;
      if (cls_if.class_valid === 1'b1) begin
        valid_lat = t;
        code = cls_if.class_code;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic accept(input int delay);
    cls_if.class_ready = 1'b0;
    repeat (delay) tick();
    cls_if.class_ready = 1'b1;
    tick();
    cls_if.class_ready = 1'b0;
    exp_count++;
  endtask

  task automatic release_obj(output bit to);
    photo = 1'b0; inductive = 1'b0; capacitive = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (2) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit seen;
    rst_n = 1'b0;
    photo = 0; inductive = 0; capacitive = 0; cls_if.class_ready = 0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cls_if.class_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cls_if.class_valid); end
    checks++; if (cls_if.class_code !== 2'b00) begin errors++; $display("FAIL reset_code got=%b exp=00", cls_if.class_code); end
    checks++; if (obj_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", obj_count); end
    rst_n = 1'b1;
    tick();
    photo = 1'b1; inductive = 1'b1;
    repeat (EXP_BUSY + 3) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_sample_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || cls_if.class_valid !== 1'b0 || cls_if.class_code !== 2'b00 || obj_count !== 8'd0)
      begin errors++; $display("FAIL reset_async got busy=%b valid=%b code=%b cnt=%0d exp all 0", busy, cls_if.class_valid, cls_if.class_code, obj_count); end
    photo = 1'b0; inductive = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cls_if.class_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_spurious got=%b exp=0", seen); end
    exp_count = 0;
  endtask

  task automatic test_debounce();
    bit seen;
    int lat;
    logic [1:0] code;
    bit to;
    seen = 1'b0;
    for (int p = 0; p < 5; p++) begin
      photo = 1'b1;
      repeat (3) begin tick(); if (busy === 1'b1) seen = 1'b1; end
      photo = 1'b0;
      repeat (3) begin tick(); if (busy === 1'b1) seen = 1'b1; end
    end
    repeat (10) begin tick(); if (busy === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL debounce_short_pulse got_busy=%b exp=0", seen); end
    photo = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 6) photo = 1'b0;
      if (busy === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != EXP_BUSY) begin errors++; $display("FAIL debounce_latency got=%0d exp=%0d", lat, EXP_BUSY); end
    to = 1'b1; code = 2'bxx;
    for (int i = 0; i < 30; i++) begin
      if (cls_if.class_valid === 1'b1) begin to = 1'b0; code = cls_if.class_code; break; end
      tick();
    end
    checks++; if (to || code !== 2'b11) begin errors++; $display("FAIL debounce_class got=%b timeout=%0d exp=11", code, to); end
    accept(0);
    release_obj(to);
    checks++; if (to || obj_count !== 8'(exp_count)) begin errors++; $display("FAIL debounce_count got=%0d exp=%0d timeout=%0d", obj_count, exp_count, to); end
  endtask

  task automatic test_metal_priority();
    logic [1:0] code; int bl, vl; bit to;
    inductive = 1'b1;
    run_obj(1'b1, 0, 1'b1, code, bl, vl, to);
    checks++; if (to || code !== 2'b01) begin errors++; $display("FAIL metal_class got=%b timeout=%0d exp=01", code, to); end
    checks++; if (vl - bl != WIN) begin errors++; $display("FAIL metal_window got=%0d exp=%0d", vl - bl, WIN); end
    checks++; if (bl != EXP_BUSY) begin errors++; $display("FAIL metal_busy_lat got=%0d exp=%0d", bl, EXP_BUSY); end
    accept(2);
    release_obj(to);
    checks++; if (to) begin errors++; $display("FAIL metal_release got=timeout exp=idle"); end
  endtask

  task automatic test_classes();
    bit         ui  [5] = '{0, 0, 1, 1, 0};
    int         dl  [5] = '{0, 0, WIN, WIN + 1, 0};
    bit         cp  [5] = '{1, 0, 0, 0, 1};
    logic [1:0] code, exp; int bl, vl; bit to;
    for (int k = 0; k < 5; k++) begin
      exp = model_class(ui[k], dl[k], cp[k]);
      run_obj(ui[k], dl[k], cp[k], code, bl, vl, to);
      checks++; if (to || code !== exp) begin errors++; $display("FAIL class_case%0d got=%b timeout=%0d exp=%b", k, code, to, exp); end
      accept(1);
      release_obj(to);
    end
  endtask

  task automatic test_handshake();
    logic [1:0] code; int bl, vl; bit to; int vcycles;
    inductive = 1'b1;
    run_obj(1'b1, 0, 1'b0, code, bl, vl, to);
    checks++; if (to || code !== 2'b01) begin errors++; $display("FAIL hs_class got=%b exp=01", code); end
    cls_if.class_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (cls_if.class_valid !== 1'b1 || cls_if.class_code !== 2'b01) begin
        errors++; $display("FAIL hs_hold cyc=%0d got valid=%b code=%b exp valid=1 code=01", i, cls_if.class_valid, cls_if.class_code);
      end
    end
    cls_if.class_ready = 1'b1;
    tick();
    cls_if.class_ready = 1'b0;
    exp_count++;
    checks++; if (cls_if.class_valid !== 1'b0 || cls_if.class_code !== 2'b00) begin errors++; $display("FAIL hs_drop got valid=%b code=%b exp 0/00", cls_if.class_valid, cls_if.class_code); end
    checks++; if (obj_count !== 8'(exp_count)) begin errors++; $display("FAIL hs_count got=%0d exp=%0d", obj_count, exp_count); end
    release_obj(to);
    cls_if.class_ready = 1'b1;
    run_obj(1'b0, 0, 1'b1, code, bl, vl, to);
    vcycles = 0;
    if (!to) begin
      vcycles = 1;
      for (int i = 0; i < 5; i++) begin tick(); if (cls_if.class_valid === 1'b1) vcycles++; end
      exp_count++;
    end
    cls_if.class_ready = 1'b0;
    checks++; if (vcycles != 1 || code !== 2'b10) begin errors++; $display("FAIL hs_ready_high got cycles=%0d code=%b exp cycles=1 code=10", vcycles, code); end
    checks++; if (obj_count !== 8'(exp_count)) begin errors++; $display("FAIL hs_ready_high_count got=%0d exp=%0d", obj_count, exp_count); end
    release_obj(to);
  endtask

  task automatic test_long_object();
    logic [1:0] code; int bl, vl; bit to, seen_valid, left_busy;
    run_obj(1'b0, 0, 1'b1, code, bl, vl, to);
    accept(0);
    photo = 1'b1; capacitive = 1'b0;
    seen_valid = 0; left_busy = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cls_if.class_valid === 1'b1) seen_valid = 1;
      if (busy !== 1'b1) left_busy = 1;
    end
    checks++; if (seen_valid || left_busy) begin errors++; $display("FAIL long_no_reclassify got valid=%0d idle=%0d exp 0/0", seen_valid, left_busy); end
    release_obj(to);
    checks++; if (to) begin errors++; $display("FAIL long_release got=timeout exp=idle"); end
    run_obj(1'b0, 0, 1'b0, code, bl, vl, to);
    checks++; if (to || code !== 2'b11) begin errors++; $display("FAIL long_rerise got=%b timeout=%0d exp=11", code, to); end
    accept(0);
    release_obj(to);
    checks++; if (obj_count !== 8'(exp_count)) begin errors++; $display("FAIL long_count got=%0d exp=%0d", obj_count, exp_count); end
  endtask

  task automatic test_random();
    logic [1:0] code, exp; int bl, vl; bit to, ui, cp; int dl;
    for (int k = 0; k < 20; k++) begin
      ui = 1'($urandom_range(0, 1));
      cp = 1'($urandom_range(0, 1));
      dl = $urandom_range(0, 12);
      exp_q.push_back(model_class(ui, dl, cp));
      run_obj(ui, dl, cp, code, bl, vl, to);
      exp = exp_q.pop_front();
      checks++; if (to || code !== exp) begin errors++; $display("FAIL rand%0d_class got=%b timeout=%0d exp=%b", k, code, to, exp); end
      checks++; if (bl != EXP_BUSY || vl != EXP_VALID) begin errors++; $display("FAIL rand%0d_timing got busy=%0d valid=%0d exp %0d/%0d", k, bl, vl, EXP_BUSY, EXP_VALID); end
      accept($urandom_range(0, 5));
      checks++; if (obj_count !== 8'(exp_count)) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", k, obj_count, exp_count); end
      release_obj(to);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] code; int bl, vl; bit to;
    int guard;
    guard = 0;
    while (exp_count < 256 && guard < 300) begin
      guard++;
      run_obj(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), code, bl, vl, to);
      if (to) begin
        checks++; errors++; $display("FAIL wrap_timeout got=timeout exp=valid at obj %0d", exp_count);
        release_obj(to);
        break;
      end
      if (exp_count == 255) begin
        checks++; if (obj_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d exp=255", obj_count); end
      end
      accept(0);
      release_obj(to);
    end
    checks++; if (obj_count !== 8'(exp_count) || exp_count != 256) begin errors++; $display("FAIL wrap_zero got=%0d after %0d objects exp=0 after 256", obj_count, exp_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    photo = 0; inductive = 0; capacitive = 0;
    cls_if.class_ready = 1'b0;
    test_reset();
    test_debounce();
    test_metal_priority();
    test_classes();
    test_handshake();
    test_long_object();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
